spi_ram_target: RTL
===================

Name: spi_ram_target

Overview:
Synthesizable SPI target (mode 0) that answers the serial-SRAM command set issued by the CPU-side SPI RAM master: READ 0x03, WRITE 0x02, 24-bit address, sequential byte streaming.
Backed by an internal byte array.
Used as on-die loopback target for the SPI RAM pins and as a bench/FPGA stand-in for an external 23LC-class SRAM.
All SPI inputs are oversampled in the system clock domain; no logic is clocked by spi_clk.

Parameters:
ADDR_W, 10, byte-address width of the internal array (depth 2**ADDR_W bytes).
SYNC_STAGES, 2, flip-flop stages on spi_clk/spi_cs_n/spi_mosi before edge detection (min 2).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
spi_clk  input  1  serial clock from master, idle low
spi_cs_n  input  1  chip select, active low
spi_mosi  input  1  serial data in, MSB first
spi_miso  output  1  serial data out, MSB first
spi_miso_oe  output  1  high while the target drives spi_miso (READ data phase only)
busy  output  1  high from synced CS_N fall until synced CS_N rise
cmd_err  output  1  one-clk pulse when an unknown opcode completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0; bit counter=0, address=0. Array contents are not reset.
- Constraint: spi_clk frequency ≤ clk/4; slower is always legal.
- Edge detect: rise/fall are single-clk pulses derived from the last two synced spi_clk samples. Edges are ignored while synced CS_N is high.
- States: IDLE -> CMD on synced CS_N fall.
  - CMD: shift 8 bits on rises. On the 8th rise:
    - 0x03 or 0x02 -> ADDR.
    - Any other value -> IGNORE, and cmd_err pulses once.
  - ADDR: shift 24 bits. Address bits above ADDR_W are discarded. On the 24th rise:
    - READ -> RDATA.
    - WRITE -> WDATA.
  - RDATA:
    - On entry, read array[addr] into the shift register within 1 clk.
    - spi_miso_oe=1 and bit7 is driven on the next fall (first data fall).
    - Each subsequent fall shifts out the next bit.
    - After 8 bits, addr increments and the next byte loads, so the following fall drives its MSB.
  - WDATA:
    - Shift on rises.
    - On every 8th rise, write the byte to array[addr] in that same clk, then increment addr.
  - IGNORE: spi_miso_oe=0, no array access.
- Address wrap: addr increments modulo 2**ADDR_W. Streaming past the top wraps to 0 for both read and write.
- CS_N rise (synced), any state:
  - Go to IDLE within 1 clk.
  - spi_miso_oe=0, spi_miso=0.
  - A partial (<8 bit) write byte is discarded.
  - Bit counter is cleared.
- CS_N fall while already busy cannot occur; CS_N is level-sampled only.
- Same-clk rise and CS_N rise: CS_N wins; no write for that clk.
- Write followed by read of the same address in a new transaction returns the new data (no hazard, since at least 2 clks separate them).
- Reset mid-transaction: state aborts immediately and a partial write is lost. Completed bytes remain in the array.

Optional Feature:
SPI_RAM_TARGET_FAST_READ_EN.
- Defined: opcode 0x0B (FAST READ) is accepted. After the 24 address bits, 8 dummy clocks are consumed (MOSI ignored, spi_miso_oe=0). Then RDATA proceeds exactly as for 0x03.
- Undefined: 0x0B is an unknown opcode -> IGNORE with a cmd_err pulse.

Decomposition:
- Package spi_ram_target_pkg:
  - opcode constants OP_READ=8'h03, OP_WRITE=8'h02, OP_FAST_READ=8'h0B
  - state enum {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE}
  - ADDR_BITS=24
- One sub-module: spi_target_sync_edge. It holds the SYNC_STAGES synchronizers for the three inputs and outputs synced cs_n, synced mosi, sck_rise and sck_fall.
- The array is an inferred reg array in the top module.

Test Plan:
- Write then read: WRITE 0x02, addr 0x000010, data A5 3C; CS_N high; then READ 0x03, addr 0x000010, 16 clocks -> MISO returns A5 then 3C, and spi_miso_oe is high only during the data bits.
- Wrap: with ADDR_W=10, WRITE at 0x0003FF with data 11 22 -> array[0x3FF]=11 and array[0x000]=22; a read from 0x3FF returns 11 22.
- Bad opcode: send 0x9F plus 32 further clocks -> cmd_err pulses once, MISO stays 0, oe stays 0, and the array is unchanged.
- Partial byte abort: WRITE to 0x20 with data 0xFF, then 5 more bits, then CS_N high -> array[0x20]=FF and array[0x21] is unchanged.
- Async reset mid-READ: assert rst_n=0 during the 3rd data bit -> spi_miso_oe=0, busy=0 and spi_miso=0 immediately; a new READ after release works.
- FAST READ (macro defined): 0x0B, addr 0x10, 8 dummy clocks, then 8 clocks -> A5. With the macro undefined, the same stimulus gives a cmd_err pulse.

Source files
------------

// File: rtl/spi_ram_target_pkg.sv
// rtl/spi_ram_target_pkg.sv - shared constants and state type for the SPI RAM target
package spi_ram_target_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int ADDR_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_target_sync_edge.sv
// rtl/spi_target_sync_edge.sv - input synchronizers and spi_clk edge detection
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   i_sck, i_cs_n, i_mosi  raw SPI pins
//   o_cs_n, o_mosi         synchronized chip select / data
//   o_sck_rise, o_sck_fall single-clk edge pulses, suppressed while o_cs_n is high
module spi_target_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   w_sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;      // deselected while in reset
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign o_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign o_sck_rise = ~o_cs_n &  w_sck & ~r_sck_d;
    assign o_sck_fall = ~o_cs_n & ~w_sck &  r_sck_d;

endmodule

// File: rtl/spi_ram_target.sv
// rtl/spi_ram_target.sv - SPI mode-0 serial-SRAM target backed by an internal byte array
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   spi_clk         serial clock from master (idle low)
//   spi_cs_n        chip select, active low
//   spi_mosi        serial data in, MSB first
//   spi_miso        serial data out, MSB first
//   spi_miso_oe     high while driving READ data
//   busy            high while synced chip select is low
//   cmd_err         one-clk pulse on an unknown opcode
// Configuration macro: SPI_RAM_TARGET_FAST_READ_EN enables opcode 0x0B with 8 dummy clocks.
module spi_ram_target
    import spi_ram_target_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy,
    output logic cmd_err
);

    logic              w_cs_n;
    logic              w_mosi;
    logic              w_rise;
    logic              w_fall;
    logic [7:0]        w_byte;
    logic              w_mem_we;

    state_t            r_state;
    logic [4:0]        r_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_read;
    logic              r_is_fast;
    logic              r_load;
    logic              r_miso;
    logic              r_oe;
    logic              r_busy;
    logic              r_cmd_err;
    logic [7:0]        r_mem [2**ADDR_W];

    spi_target_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sck      (spi_clk),
        .i_cs_n     (spi_cs_n),
        .i_mosi     (spi_mosi),
        .o_cs_n     (w_cs_n),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_rise),
        .o_sck_fall (w_fall)
    );

    assign w_byte   = {r_shift[6:0], w_mosi};
    assign w_mem_we = ~w_cs_n & w_rise & (r_state == WDATA) & (r_cnt == 5'd7);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= w_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_is_read <= 1'b0;
            r_is_fast <= 1'b0;
            r_load    <= 1'b0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            if (w_cs_n) begin
                // Deselect aborts everything, including a partially shifted write byte.
                r_state <= IDLE;
                r_cnt   <= '0;
                r_load  <= 1'b0;
                r_miso  <= 1'b0;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_busy <= 1'b1;
                case (r_state)
                    // IDLE shares the opcode shifter so a rise in the first selected clk is not lost.
                    IDLE, CMD: begin
                        r_state <= CMD;
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 5'd1;
                            if (r_cnt == 5'd7) begin
                                r_cnt     <= '0;
                                r_is_fast <= 1'b0;
                                if (w_byte == OP_READ || w_byte == OP_WRITE) begin
                                    r_state   <= ADDR;
                                    r_is_read <= (w_byte == OP_READ);
`ifdef SPI_RAM_TARGET_FAST_READ_EN
                                end else if (w_byte == OP_FAST_READ) begin
                                    r_state   <= ADDR;
                                    r_is_read <= 1'b1;
                                    r_is_fast <= 1'b1;
`endif
                                end else begin
                                    r_state   <= IGNORE;
                                    r_cmd_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (w_rise) begin
                            // Shifting through an ADDR_W-wide register drops the upper address bits.
                            r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
                            r_cnt  <= r_cnt + 5'd1;
                            if (r_cnt == 5'(ADDR_BITS - 1)) begin
                                r_cnt <= '0;
                                if (r_is_fast) begin
                                    r_state <= DUMMY;
                                end else if (r_is_read) begin
                                    r_state <= RDATA;
                                    r_load  <= 1'b1;
                                end else begin
                                    r_state <= WDATA;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (w_rise) begin
                            r_cnt <= r_cnt + 5'd1;
                            if (r_cnt == 5'd7) begin
                                r_cnt   <= '0;
                                r_state <= RDATA;
                                r_load  <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        // Load happens one clk after the address settles; the clk/4 limit keeps
                        // it clear of the next fall.
                        if (r_load) begin
                            r_tx   <= r_mem[r_addr];
                            r_load <= 1'b0;
                        end else if (w_fall) begin
                            r_miso <= r_tx[7];
                            r_oe   <= 1'b1;
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_cnt  <= r_cnt + 5'd1;
                            if (r_cnt == 5'd7) begin
                                r_cnt  <= '0;
                                r_addr <= r_addr + ADDR_W'(1);
                                r_load <= 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 5'd1;
                            if (r_cnt == 5'd7) begin
                                r_cnt  <= '0;
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end
                    end
                    IGNORE: begin
                        r_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign busy        = r_busy;
    assign cmd_err     = r_cmd_err;

endmodule
